// File: rtl/tlc_pkg.sv
// Shared types and constants for the timed traffic-light controller.
package tlc_pkg;

    typedef logic [1:0] light_t;

    localparam light_t GREEN  = 2'd0;
    localparam light_t YELLOW = 2'd1;
    localparam light_t RED    = 2'd2;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin selector: first set demand bit after cur_i,
// wrapping, with cur_i itself checked last.
module tlc_rr_pick #(
    parameter int NUM_DIR = 2
) (
    input  logic [NUM_DIR-1:0]         demand_i,
    input  logic [$clog2(NUM_DIR)-1:0] cur_i,
    output logic [$clog2(NUM_DIR)-1:0] idx_o,
    output logic                       valid_o
);
    localparam int DW = $clog2(NUM_DIR);

    int j;

    // Scan from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            j = (int'(cur_i) + k) % NUM_DIR;
            if (demand_i[j]) begin
                idx_o   = DW'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_timed.sv
// Timed traffic-light controller with min/max green and round-robin service.
// Define TLC_ALLRED_EN to insert an all-red clearance after each yellow.
module tlc_timed
    import tlc_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_DIR-1:0]         sense,
    output logic [2*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] cur_dir,
    output logic [1:0]                 phase
);
    localparam int DW   = $clog2(NUM_DIR);
    localparam int MAXD = max_int(max_int(MIN_GREEN, MAX_GREEN), max_int(YELLOW_CYC, ALLRED_CYC));
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [TW-1:0] MING_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAXG_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_CYC - 1);
`ifdef TLC_ALLRED_EN
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_CYC - 1);
`endif

    phase_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [DW-1:0]        cur_q, cur_d;
    logic [DW-1:0]        nxt_q, nxt_d;
    logic [2*NUM_DIR-1:0] lights_q, lights_d;

    logic [NUM_DIR-1:0]   other;
    logic [DW-1:0]        pick_idx;
    logic                 pick_vld;

    assign other = sense & ~(NUM_DIR'(1) << cur_q);

    tlc_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
        .demand_i (other),
        .cur_i    (cur_q),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PH_GREEN;
            timer_q <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            for (int i = 0; i < NUM_DIR; i++)
                lights_q[2*i +: 2] <= (i == 0) ? GREEN : RED;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            lights_q <= lights_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        case (state_q)
            PH_GREEN: begin
                // pick_vld is exactly "some other approach is waiting".
                if (timer_q >= MING_LAST && pick_vld && (!sense[cur_q] || timer_q == MAXG_LAST)) begin
                    state_d = PH_YELLOW;
                    timer_d = '0;
                    nxt_d   = pick_idx;
                end else if (timer_q != MAXG_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PH_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    timer_d = '0;
`ifdef TLC_ALLRED_EN
                    state_d = PH_ALLRED;
`else
                    state_d = PH_GREEN;
                    cur_d   = nxt_q;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PH_ALLRED: begin
`ifdef TLC_ALLRED_EN
                if (timer_q == AR_LAST) begin
                    state_d = PH_GREEN;
                    timer_d = '0;
                    cur_d   = nxt_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`else
                state_d = PH_GREEN;
                timer_d = '0;
                cur_d   = nxt_q;
`endif
            end
            default: begin
                state_d = PH_GREEN;
                timer_d = '0;
            end
        endcase
    end

    // Lamps are derived from the next state so they register alongside it.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lights_d[2*i +: 2] = RED;
            if (DW'(i) == cur_d) begin
                if (state_d == PH_GREEN)
                    lights_d[2*i +: 2] = GREEN;
                else if (state_d == PH_YELLOW)
                    lights_d[2*i +: 2] = YELLOW;
            end
        end
    end

    assign lights  = lights_q;
    assign cur_dir = cur_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_tlc_timed.sv
// Directed self-checking bench for tlc_timed (2-approach and 4-approach builds).
module tb_tlc_timed;

`ifdef TLC_ALLRED_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif
    localparam int P = 8 + 2 + AR;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sense;
    logic [3:0] lights;
    logic [0:0] cur_dir;
    logic [1:0] phase;

    logic [3:0] sense4;
    logic [7:0] lights4;
    logic [1:0] cur4;
    logic [1:0] phase4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tlc_timed dut (
        .clock   (clk),
        .reset_n (rst_n),
        .sense   (sense),
        .lights  (lights),
        .cur_dir (cur_dir),
        .phase   (phase)
    );

    tlc_timed #(.NUM_DIR(4)) dut4 (
        .clock   (clk),
        .reset_n (rst_n),
        .sense   (sense4),
        .lights  (lights4),
        .cur_dir (cur4),
        .phase   (phase4)
    );

    function automatic logic [3:0] exp2(input int ph, input int d);
        logic [3:0] v;
        v = 4'b1010;
        if (ph == 0)      v[2*d +: 2] = 2'b00;
        else if (ph == 1) v[2*d +: 2] = 2'b01;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic [1:0] s, input logic [3:0] s4);
        rst_n  = 1'b0;
        sense  = s;
        sense4 = s4;
        tick();
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sense = 2'b11; sense4 = 4'b1111;
        tick(); tick();
        n_cmp++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL reset_lights got %b want 1000", lights); end
        n_cmp++; if (cur_dir !== 1'b0) begin n_fail++; $display("FAIL reset_cur got %0d want 0", cur_dir); end
        n_cmp++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_cmp++; if (lights4 !== 8'b10101000) begin n_fail++; $display("FAIL reset_lights4 got %b want 10101000", lights4); end
    endtask

    task automatic test_reset_mid_yellow();
        hold_reset(2'b10, 4'b0000);
        for (int e = 0; e < 5; e++) tick();
        n_cmp++; if (phase !== 2'd1) begin n_fail++; $display("FAIL midyel_pre_phase got %0d want 1", phase); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL midyel_lights got %b want 1000", lights); end
        n_cmp++; if (phase !== 2'd0) begin n_fail++; $display("FAIL midyel_phase got %0d want 0", phase); end
        n_cmp++; if (cur_dir !== 1'b0) begin n_fail++; $display("FAIL midyel_cur got %0d want 0", cur_dir); end
    endtask

    task automatic test_single_demand();
        int ph, d;
        hold_reset(2'b10, 4'b0000);
        for (int e = 1; e <= 6 + AR; e++) begin
            tick();
            if (e < 4)           begin ph = 0; d = 0; end
            else if (e < 6)      begin ph = 1; d = 0; end
            else if (e < 6 + AR) begin ph = 2; d = 0; end
            else                 begin ph = 0; d = 1; end
            n_cmp++; if (phase !== 2'(ph)) begin n_fail++; $display("FAIL single_phase edge %0d got %0d want %0d", e, phase, ph); end
            n_cmp++; if (cur_dir !== 1'(d)) begin n_fail++; $display("FAIL single_cur edge %0d got %0d want %0d", e, cur_dir, d); end
            n_cmp++; if (lights !== exp2(ph, d)) begin n_fail++; $display("FAIL single_lights edge %0d got %b want %b", e, lights, exp2(ph, d)); end
        end
    endtask

    task automatic test_max_green();
        int ph, d, r;
        hold_reset(2'b11, 4'b0000);
        for (int e = 1; e <= 2 * P + 3; e++) begin
            tick();
            r  = e % P;
            d  = (e / P) % 2;
            ph = (r < 8) ? 0 : (r < 10) ? 1 : 2;
            n_cmp++; if (phase !== 2'(ph)) begin n_fail++; $display("FAIL maxg_phase edge %0d got %0d want %0d", e, phase, ph); end
            n_cmp++; if (cur_dir !== 1'(d)) begin n_fail++; $display("FAIL maxg_cur edge %0d got %0d want %0d", e, cur_dir, d); end
            n_cmp++; if (lights !== exp2(ph, d)) begin n_fail++; $display("FAIL maxg_lights edge %0d got %b want %b", e, lights, exp2(ph, d)); end
        end
    endtask

    task automatic test_resting();
        hold_reset(2'b00, 4'b0000);
        for (int e = 0; e < 100; e++) tick();
        n_cmp++; if (phase !== 2'd0 || cur_dir !== 1'b0) begin n_fail++; $display("FAIL rest_state got ph %0d cur %0d want ph 0 cur 0", phase, cur_dir); end
        n_cmp++; if (dut.timer_q !== 3'd7) begin n_fail++; $display("FAIL rest_timer got %0d want 7", dut.timer_q); end
        sense = 2'b11;
        tick();
        n_cmp++; if (phase !== 2'd1) begin n_fail++; $display("FAIL rest_leave got %0d want 1", phase); end
    endtask

    task automatic test_round_robin();
        int cnt;
        hold_reset(2'b00, 4'b0100);
        for (int e = 0; e < 6 + AR; e++) tick();
        n_cmp++; if (cur4 !== 2'd2 || phase4 !== 2'd0) begin n_fail++; $display("FAIL rr_first got cur %0d ph %0d want cur 2 ph 0", cur4, phase4); end
        sense4 = 4'b0011;
        for (int e = 0; e < 4; e++) tick();
        n_cmp++; if (phase4 !== 2'd1) begin n_fail++; $display("FAIL rr_min_leave got %0d want 1", phase4); end
        cnt = 0;
        while (phase4 !== 2'd0 && cnt < 40) begin tick(); cnt++; end
        n_cmp++; if (cnt >= 40) begin n_fail++; $display("FAIL rr_wait0 got timeout want green"); end
        n_cmp++; if (cur4 !== 2'd0) begin n_fail++; $display("FAIL rr_next0 got %0d want 0", cur4); end
        n_cmp++; if (lights4 !== 8'b10101000) begin n_fail++; $display("FAIL rr_lights0 got %b want 10101000", lights4); end
        for (int e = 0; e < 7; e++) tick();
        n_cmp++; if (phase4 !== 2'd0) begin n_fail++; $display("FAIL rr_hold7 got %0d want 0", phase4); end
        tick();
        n_cmp++; if (phase4 !== 2'd1) begin n_fail++; $display("FAIL rr_max8 got %0d want 1", phase4); end
        cnt = 0;
        while (phase4 !== 2'd0 && cnt < 40) begin tick(); cnt++; end
        n_cmp++; if (cnt >= 40) begin n_fail++; $display("FAIL rr_wait1 got timeout want green"); end
        n_cmp++; if (cur4 !== 2'd1) begin n_fail++; $display("FAIL rr_next1 got %0d want 1", cur4); end
    endtask

    initial begin
        rst_n = 1'b0; sense = '0; sense4 = '0;
        test_reset();
        test_reset_mid_yellow();
        test_single_demand();
        test_max_green();
        test_resting();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_timed.md
# tlc_timed

Parametrised, timed traffic-light controller for an intersection of NUM_DIR approaches. It replaces two-road, sensor-only phase stepping with cycle-counted minimum and maximum green, a fixed yellow interval, an optional all-red clearance and round-robin service of waiting approaches. It sits between the sensor interface and the lamp drivers, and exposes the active approach for status and logging.

## Interface
- NUM_DIR, 2: number of approaches, must be ≥2.
- MIN_GREEN, 4: minimum green length in cycles, must be ≥1.
- MAX_GREEN, 8: maximum green length in cycles when any other approach is waiting, must be ≥MIN_GREEN.
- YELLOW_CYC, 2: yellow length in cycles, must be ≥1.
- ALLRED_CYC, 1: all-red clearance length in cycles, must be ≥1; used only with TLC_ALLRED_EN.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sense  in  NUM_DIR  bit i = 1 while traffic waits on approach i; synchronous to clock.
- lights  out  2*NUM_DIR  approach i occupies bits [2i+1:2i], encoded green=0, yellow=1, red=2 (3 is never driven).
- cur_dir  out  $clog2(NUM_DIR)  index of the approach that is green, yellow or last served.
- phase  out  2  current state: GREEN=0, YELLOW=1, ALLRED=2.

## Operation
- All outputs are registered.
- Reset values:
  - state GREEN, cur_dir 0, timer 0.
  - lights: approach 0 green, all others red.
  - next-direction register 0.
- Timer: cleared on every state entry and incremented on each clock in the state. Width is $clog2 of the largest duration.
- GREEN:
  - Other demand is sense with bit cur_dir masked off.
  - Leave GREEN when timer ≥ MIN_GREEN−1 and other demand ≠ 0 and either sense[cur_dir] = 0 or timer = MAX_GREEN−1.
  - With no other demand, stay green indefinitely and saturate the timer at MAX_GREEN−1.
- Next approach:
  - Latched on the GREEN→YELLOW edge.
  - It is the first set bit of other demand searching cur_dir+1, cur_dir+2, …, wrapping modulo NUM_DIR.
- YELLOW:
  - lights[cur_dir] = yellow, all other approaches red.
  - After YELLOW_CYC cycles, go to ALLRED when TLC_ALLRED_EN is defined, otherwise to GREEN.
- ALLRED: all approaches red for ALLRED_CYC cycles, then GREEN.
- On entering GREEN: cur_dir takes the latched next value, that approach turns green and all others are red.
- Sense changes after the GREEN→YELLOW decision do not abort the phase; the latched target is always served.
- Invariant: at most one approach is non-red at any time.

## Timing
- Decisions use sense as sampled on the same rising edge, with no input synchroniser.
- Minimum green is MIN_GREEN cycles, maximum is MAX_GREEN cycles while contended.
- Yellow lasts exactly YELLOW_CYC cycles and all-red exactly ALLRED_CYC cycles.
- Turnaround from the end of a green to the next green is YELLOW_CYC (+ALLRED_CYC) cycles.
- Reset asserted at any point, including mid-yellow or mid-all-red, forces the reset values immediately. Operation resumes at the first rising edge after release.

## Configuration
- TLC_ALLRED_EN:
  - Defined: the ALLRED state, its timer compare and the ALLRED_CYC parameter are active.
  - Undefined: YELLOW goes straight to GREEN, the phase value 2 is never produced and ALLRED_CYC is ignored.

## Structure
- tlc_pkg holds:
  - light encoding constants GREEN, YELLOW and RED;
  - the phase enum typedef;
  - the light_t 2-bit typedef.
- One sub-module, tlc_rr_pick: combinational round-robin selector taking demand mask and cur_dir, returning the next index and a valid flag. It is reusable for the arbiters.

## Test plan
Use defaults unless stated.
- **Reset:** hold reset_n = 0 -> lights = {red, green} (approach 1 red, approach 0 green), cur_dir 0, phase 0. Assert reset_n mid-yellow -> same values immediately, with no clock edge required.
- **Single demand:** release reset with sense = 2'b10 -> approach 0 green for 4 cycles, yellow for 2, all-red for 1. Approach 1 goes green on the 7th rising edge after release.
- **Max green:** sense = 2'b11 constant -> greens alternate, each exactly 8 cycles, each separated by 2 yellow + 1 all-red.
- **Resting:** sense = 0 -> approach 0 stays green for 100 cycles and the timer saturates at 7.
- **Round-robin:** NUM_DIR = 4, cur_dir 2, sense = 4'b0011 -> next green is approach 0, then approach 1.
- **Macro off:** repeat the single-demand case without TLC_ALLRED_EN -> approach 1 goes green on the 6th edge and phase never equals 2.
